// File: rtl/ex_stage_md_if.sv
// rtl/ex_stage_md_if.sv - ID/EX-side bundle for the execute stage with forwarding and M-extension engine
//
// Purpose: groups every non-clock/reset signal of ex_stage_md.
// Ports (signals):
//   in_valid, flush            instruction present / kill it
//   data_rs1/rs2/imm/pc        operands from the ID/EX register
//   fwd_data, fwd_a/b_sel      forwarding sources and per-operand selects
//   alu_src_a/b, alu_func,     ALU operand muxing and ALUCtrl inputs
//   alu_op
//   md_en, md_func             RV32M instruction and its funct3
//   result, result_valid       EX result toward EX/MEM
//   stall                      hold IF/ID/EX
//   rs2_fwd                    forwarded rs2 (store data)
// Modports: master drives the instruction side, slave is the execute stage.

interface ex_stage_md_if #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int NUM_FWD  = 2,
    parameter int SELW     = $clog2(NUM_FWD + 1)
);
    logic                        in_valid;
    logic                        flush;
    logic [DWIDTH-1:0]           data_rs1;
    logic [DWIDTH-1:0]           data_rs2;
    logic [DWIDTH-1:0]           data_imm;
    logic [PC_WIDTH-1:0]         data_pc;
    logic [NUM_FWD*DWIDTH-1:0]   fwd_data;
    logic [SELW-1:0]             fwd_a_sel;
    logic [SELW-1:0]             fwd_b_sel;
    logic [1:0]                  alu_src_a;
    logic [1:0]                  alu_src_b;
    logic [3:0]                  alu_func;
    logic [1:0]                  alu_op;
    logic                        md_en;
    logic [2:0]                  md_func;
    logic [DWIDTH-1:0]           result;
    logic                        result_valid;
    logic                        stall;
    logic [DWIDTH-1:0]           rs2_fwd;

    modport master (
        output in_valid, flush, data_rs1, data_rs2, data_imm, data_pc,
               fwd_data, fwd_a_sel, fwd_b_sel, alu_src_a, alu_src_b,
               alu_func, alu_op, md_en, md_func,
        input  result, result_valid, stall, rs2_fwd
    );

    modport slave (
        input  in_valid, flush, data_rs1, data_rs2, data_imm, data_pc,
               fwd_data, fwd_a_sel, fwd_b_sel, alu_src_a, alu_src_b,
               alu_func, alu_op, md_en, md_func,
        output result, result_valid, stall, rs2_fwd
    );
endinterface

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - RV32 execute stage: N-source forwarding, single-cycle ALU, iterative RV32M engine
//
// Purpose: operand forwarding muxes feed the ALU (ALUCtrl decode included)
// and a shift-add multiplier / restoring divider. M-extension ops stall the
// front of the pipe until their registered result is presented in DONE.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   ex_stage_md_if.slave (see interface file for the signal list)
// Build option: define EX_MD_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU
// with a single-cycle combinational multiplier (IDLE->DONE in one cycle).

module ex_stage_md #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32,
    parameter int NUM_FWD  = 2,
    parameter int SELW     = $clog2(NUM_FWD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    ex_stage_md_if.slave  bus
);

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [DWIDTH-1:0] MIN_VAL = {1'b1, {(DWIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Forwarding: select 0 is the register file, k picks source k-1, and
    // anything beyond NUM_FWD falls back to the register file.
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] fwd_a;
    logic [DWIDTH-1:0] fwd_b;

    always_comb begin
        fwd_a = bus.data_rs1;
        fwd_b = bus.data_rs2;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (int'(bus.fwd_a_sel) == k + 1) fwd_a = bus.fwd_data[k*DWIDTH +: DWIDTH];
            if (int'(bus.fwd_b_sel) == k + 1) fwd_b = bus.fwd_data[k*DWIDTH +: DWIDTH];
        end
    end

    // ------------------------------------------------------------------
    // ALUCtrl: alu_op 00 = add (address/link), 01 = sub (branch compare),
    // 10 = R-type (funct7[5] selects SUB/SRA), 11 = I-type (funct7[5]
    // only matters for the right shift, so ADDI never becomes SUB).
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_ctl_e;

    alu_ctl_e alu_ctl;

    always_comb begin
        alu_ctl = ALU_ADD;
        case (bus.alu_op)
            2'b00: alu_ctl = ALU_ADD;
            2'b01: alu_ctl = ALU_SUB;
            default: begin
                case (bus.alu_func[2:0])
                    3'b000: alu_ctl = (bus.alu_op == 2'b10 && bus.alu_func[3]) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_ctl = ALU_SLL;
                    3'b010: alu_ctl = ALU_SLT;
                    3'b011: alu_ctl = ALU_SLTU;
                    3'b100: alu_ctl = ALU_XOR;
                    3'b101: alu_ctl = bus.alu_func[3] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctl = ALU_OR;
                    default: alu_ctl = ALU_AND;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic [CW-1:0]     shamt;
    logic [DWIDTH-1:0] alu_out;

    always_comb begin
        alu_a = (bus.alu_src_a == 2'b10) ? DWIDTH'(bus.data_pc) : fwd_a;
        case (bus.alu_src_b)
            2'b01:   alu_b = bus.data_imm;
            2'b10:   alu_b = DWIDTH'(4);
            default: alu_b = fwd_b;
        endcase
    end

    assign shamt = alu_b[CW-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_ctl)
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_SLL:  alu_out = alu_a << shamt;
            ALU_SLT:  alu_out = {{(DWIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_out = {{(DWIDTH-1){1'b0}}, (alu_a < alu_b)};
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_SRL:  alu_out = alu_a >> shamt;
            ALU_SRA:  alu_out = $signed(alu_a) >>> shamt;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_AND:  alu_out = alu_a & alu_b;
            default:  alu_out = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // M-extension operand preparation (evaluated in the start cycle).
    // The engine works on magnitudes; signs are reapplied at the end.
    // ------------------------------------------------------------------
    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic [DWIDTH-1:0] a_mag;
    logic [DWIDTH-1:0] b_mag;
    logic              is_div;
    logic              div_zero;
    logic              div_ovf;

    always_comb begin
        // MUL, MULH, MULHSU, DIV, REM treat rs1 as signed.
        a_signed = (bus.md_func != 3'b011) && !(bus.md_func[2] && bus.md_func[0]);
        // MUL, MULH, DIV, REM treat rs2 as signed.
        b_signed = (bus.md_func[2:1] == 2'b00) || (bus.md_func[2] && !bus.md_func[0]);
    end

    assign a_neg    = a_signed & fwd_a[DWIDTH-1];
    assign b_neg    = b_signed & fwd_b[DWIDTH-1];
    assign a_mag    = a_neg ? -fwd_a : fwd_a;
    assign b_mag    = b_neg ? -fwd_b : fwd_b;
    assign is_div   = bus.md_func[2];
    assign div_zero = is_div && (fwd_b == '0);
    // Only the signed forms (DIV/REM, funct3[0]=0) can overflow.
    assign div_ovf  = is_div && !bus.md_func[0] && (fwd_a == MIN_VAL) && (fwd_b == '1);

`ifdef EX_MD_FAST_MUL_EN
    logic [2*DWIDTH-1:0] fast_prod;
    assign fast_prod = {{DWIDTH{1'b0}}, a_mag} * {{DWIDTH{1'b0}}, b_mag};
`endif

    // Applies the deferred sign and picks the half/quotient/remainder.
    function automatic logic [DWIDTH-1:0] md_finish(input logic [2:0]          f,
                                                    input logic                neg,
                                                    input logic                nega,
                                                    input logic [2*DWIDTH-1:0] p);
        logic [2*DWIDTH-1:0] full;
        logic [DWIDTH-1:0]   quo;
        logic [DWIDTH-1:0]   rem;
        full = neg  ? -p : p;
        quo  = neg  ? -p[DWIDTH-1:0] : p[DWIDTH-1:0];
        rem  = nega ? -p[2*DWIDTH-1:DWIDTH] : p[2*DWIDTH-1:DWIDTH];
        if (f[2]) md_finish = f[1] ? rem : quo;
        else      md_finish = (f[1:0] == 2'b00) ? full[DWIDTH-1:0] : full[2*DWIDTH-1:DWIDTH];
    endfunction

    // ------------------------------------------------------------------
    // Iteration datapath. prod_q holds {acc, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; opnd_q is the multiplicand
    // or the divisor.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

    md_state_e           state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          func_q;
    logic                neg_q;
    logic                nega_q;
    logic [DWIDTH-1:0]   opnd_q;
    logic [2*DWIDTH-1:0] prod_q;
    logic [DWIDTH-1:0]   res_q;

    logic [DWIDTH:0]     mul_sum;
    logic [DWIDTH:0]     div_trial;
    logic [2*DWIDTH-1:0] step_d;
    logic                start;

    assign mul_sum   = {1'b0, prod_q[2*DWIDTH-1:DWIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // Shifted partial remainder minus divisor; bit DWIDTH set means it did not fit.
    assign div_trial = {prod_q[2*DWIDTH-1:DWIDTH], prod_q[DWIDTH-1]} - {1'b0, opnd_q};

    always_comb begin
        if (func_q[2]) begin
            step_d = div_trial[DWIDTH] ? {prod_q[2*DWIDTH-2:0], 1'b0}
                                       : {div_trial[DWIDTH-1:0], prod_q[DWIDTH-2:0], 1'b1};
        end else begin
            step_d = {mul_sum, prod_q[DWIDTH-1:1]};
        end
    end

    assign start = (state_q == MD_IDLE) && bus.in_valid && bus.md_en && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            opnd_q  <= '0;
            prod_q  <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        func_q <= bus.md_func;
                        neg_q  <= a_neg ^ b_neg;
                        nega_q <= a_neg;
                        cnt_q  <= '0;
                        if (div_zero) begin
                            res_q   <= bus.md_func[1] ? fwd_a : '1;
                            state_q <= MD_DONE;
                        end else if (div_ovf) begin
                            res_q   <= bus.md_func[1] ? '0 : MIN_VAL;
                            state_q <= MD_DONE;
`ifdef EX_MD_FAST_MUL_EN
                        end else if (!is_div) begin
                            res_q   <= md_finish(bus.md_func, a_neg ^ b_neg, a_neg, fast_prod);
                            state_q <= MD_DONE;
`endif
                        end else begin
                            opnd_q  <= is_div ? b_mag : a_mag;
                            prod_q  <= {{DWIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                            state_q <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    if (bus.flush) begin
                        state_q <= MD_IDLE;
                    end else begin
                        prod_q <= step_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(DWIDTH - 1)) begin
                            res_q   <= md_finish(func_q, neg_q, nega_q, step_d);
                            state_q <= MD_DONE;
                        end
                    end
                end
                default: begin
                    // DONE always returns to IDLE; flush here only suppresses result_valid.
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The start-cycle stall is combinational so the front of the
    // pipe holds in the very cycle the M op is recognised.
    // ------------------------------------------------------------------
    assign bus.stall        = !rst && (start || (state_q == MD_RUN));
    assign bus.result_valid = !rst && ((state_q == MD_DONE)
                                       ? !bus.flush
                                       : ((state_q == MD_IDLE) && bus.in_valid && !bus.md_en && !bus.flush));
    assign bus.result       = (state_q == MD_DONE) ? res_q : alu_out;
    assign bus.rs2_fwd      = fwd_b;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - self-checking bench for ex_stage_md (table vectors + scoreboard)

module tb_ex_stage_md;

    localparam int W  = 32;
    localparam int NF = 3;
    localparam int SW = 3;
`ifdef EX_MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_md_if #(.DWIDTH(W), .PC_WIDTH(W), .NUM_FWD(NF), .SELW(SW)) bus ();

    ex_stage_md #(.DWIDTH(W), .PC_WIDTH(W), .NUM_FWD(NF), .SELW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        md;
        logic [2:0]  mf;
        logic [1:0]  aop;
        logic [3:0]  af;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [2:0]  asel;
        logic [2:0]  bsel;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] fsrc[3];
    vec_t        tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t av(input logic [1:0] aop, input logic [3:0] af,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [2:0] asel, input logic [2:0] bsel,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [31:0] exp);
        vec_t v;
        v.md = 1'b0; v.mf = 3'b000; v.aop = aop; v.af = af; v.sa = sa; v.sb = sb;
        v.asel = asel; v.bsel = bsel; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
        v.exp = exp; v.lat = 0;
        return v;
    endfunction

    function automatic vec_t mv(input logic [2:0] mf, input logic [2:0] asel,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.md = 1'b1; v.mf = mf; v.aop = 2'b00; v.af = 4'b0000; v.sa = 2'b00; v.sb = 2'b00;
        v.asel = asel; v.bsel = 3'd0; v.rs1 = rs1; v.rs2 = rs2; v.imm = '0; v.pc = '0;
        v.exp = exp; v.lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] fwd_model(input logic [2:0] sel, input logic [31:0] rf);
        int s;
        s = int'(sel);
        if (s == 0 || s > NF) return rf;
        return fsrc[s-1];
    endfunction

    task automatic drive_vec(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b0;
        bus.md_en     = v.md;
        bus.md_func   = v.mf;
        bus.alu_op    = v.aop;
        bus.alu_func  = v.af;
        bus.alu_src_a = v.sa;
        bus.alu_src_b = v.sb;
        bus.fwd_a_sel = v.asel;
        bus.fwd_b_sel = v.bsel;
        bus.data_rs1  = v.rs1;
        bus.data_rs2  = v.rs2;
        bus.data_imm  = v.imm;
        bus.data_pc   = v.pc;
        bus.fwd_data  = {fsrc[2], fsrc[1], fsrc[0]};
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that retires the op.
    task automatic apply(input vec_t v, input int idx);
        int          stalls;
        int          lat;
        bit          got;
        logic [31:0] e;
        drive_vec(v);
        exp_q.push_back(v.exp);
        stalls = 0;
        lat    = -1;
        got    = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            if (c == 0) check($sformatf("vec%0d rs2_fwd", idx), bus.rs2_fwd, fwd_model(v.bsel, v.rs2));
            if (bus.stall) stalls++;
            if (bus.result_valid) begin
                got = 1'b1;
                lat = c;
                e   = exp_q.pop_front();
                check($sformatf("vec%0d result", idx), bus.result, e);
            end
            @(posedge clk);
            #1;
        end
        if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
        check_int($sformatf("vec%0d latency", idx), lat, v.lat);
        check_int($sformatf("vec%0d stall_cycles", idx), stalls, v.lat);
        bus.in_valid = 1'b0;
        bus.md_en    = 1'b0;
    endtask

    initial begin
        int   cnt;
        vec_t v;

        fsrc[0] = 32'h11111111;
        fsrc[1] = 32'h22220000;
        fsrc[2] = 32'h00003333;

        rst = 1'b1;
        v = av(2'b00, 4'b0000, 2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        drive_vec(v);
        bus.in_valid = 1'b0;

        // ALU path
        tbl.push_back(av(2'b00, 4'b0000, 2'b00, 2'b00, 3'd2, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h22223333));
        tbl.push_back(av(2'b00, 4'b0000, 2'b10, 2'b01, 3'd0, 3'd0, 32'hDEAD, 32'h0, 32'h24, 32'h1000, 32'h1024));
        tbl.push_back(av(2'b00, 4'b0000, 2'b00, 2'b00, 3'd5, 3'd0, 32'h100, 32'h23, 32'h0, 32'h0, 32'h123));
        tbl.push_back(av(2'b10, 4'b1000, 2'b00, 2'b00, 3'd0, 3'd0, 32'd5, 32'd7, 32'h0, 32'h0, 32'hFFFFFFFE));
        tbl.push_back(av(2'b10, 4'b1101, 2'b00, 2'b00, 3'd0, 3'd0, 32'h80000000, 32'd4, 32'h0, 32'h0, 32'hF8000000));
        tbl.push_back(av(2'b10, 4'b0101, 2'b00, 2'b00, 3'd0, 3'd0, 32'h80000000, 32'd4, 32'h0, 32'h0, 32'h08000000));
        tbl.push_back(av(2'b11, 4'b0011, 2'b00, 2'b01, 3'd0, 3'd0, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1));
        tbl.push_back(av(2'b10, 4'b0010, 2'b00, 2'b00, 3'd0, 3'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'h1));
        tbl.push_back(av(2'b11, 4'b1000, 2'b00, 2'b01, 3'd0, 3'd0, 32'd10, 32'h0, 32'hFFFFFFFF, 32'h0, 32'd9));
        tbl.push_back(av(2'b00, 4'b0000, 2'b10, 2'b10, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h2000, 32'h2004));
        tbl.push_back(av(2'b01, 4'b0000, 2'b00, 2'b00, 3'd0, 3'd0, 32'd10, 32'd3, 32'h0, 32'h0, 32'd7));
        tbl.push_back(av(2'b10, 4'b0111, 2'b00, 2'b00, 3'd0, 3'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'hF000));
        // M-extension path (consecutive entries run back-to-back)
        tbl.push_back(mv(3'b000, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT));
        tbl.push_back(mv(3'b011, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT));
        tbl.push_back(mv(3'b001, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT));
        tbl.push_back(mv(3'b010, 3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT));
        tbl.push_back(mv(3'b000, 3'd1, 32'h0, 32'd3, 32'h33333333, MUL_LAT));
        tbl.push_back(mv(3'b100, 3'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT));
        tbl.push_back(mv(3'b110, 3'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT));
        tbl.push_back(mv(3'b101, 3'd0, 32'd100, 32'd7, 32'd14, DIV_LAT));
        tbl.push_back(mv(3'b111, 3'd0, 32'd100, 32'd7, 32'd2, DIV_LAT));
        tbl.push_back(mv(3'b100, 3'd0, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT));
        tbl.push_back(mv(3'b110, 3'd0, 32'd100, 32'hFFFFFFF9, 32'd2, DIV_LAT));
        tbl.push_back(mv(3'b101, 3'd0, 32'd5, 32'd0, 32'hFFFFFFFF, 1));
        tbl.push_back(mv(3'b110, 3'd0, 32'd5, 32'd0, 32'd5, 1));
        tbl.push_back(mv(3'b100, 3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
        tbl.push_back(mv(3'b110, 3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(av(2'b00, 4'b0000, 2'b00, 2'b00, 3'd0, 3'd0, 32'd1, 32'd2, 32'h0, 32'h0, 32'd3));

        // Reset: outputs quiet even with an M op presented.
        repeat (2) @(posedge clk);
        #1;
        v = mv(3'b100, 3'd0, 32'd9, 32'd3, 32'd3, DIV_LAT);
        drive_vec(v);
        @(negedge clk);
        check("reset stall", {31'b0, bus.stall}, 32'h0);
        check("reset result_valid", {31'b0, bus.result_valid}, 32'h0);
        bus.in_valid = 1'b0;
        bus.md_en    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset stall", {31'b0, bus.stall}, 32'h0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Flush during RUN.
        v = mv(3'b101, 3'd0, 32'd1000, 32'd3, 32'd333, DIV_LAT);
        drive_vec(v);
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush-cycle stall", {31'b0, bus.stall}, 32'h1);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.md_en    = 1'b0;
        @(negedge clk);
        check("after-flush stall", {31'b0, bus.stall}, 32'h0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid || bus.stall) cnt++;
        end
        check_int("flush no result/stall", cnt, 0);

        // Flush in the start cycle: nothing starts.
        @(posedge clk);
        #1;
        drive_vec(v);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush-start stall", {31'b0, bus.stall}, 32'h0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.md_en    = 1'b0;
        @(negedge clk);
        check("flush-start idle", {31'b0, bus.stall}, 32'h0);

        // Async reset mid-divide.
        @(posedge clk);
        #1;
        drive_vec(v);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async-rst stall", {31'b0, bus.stall}, 32'h0);
        check("async-rst result_valid", {31'b0, bus.result_valid}, 32'h0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.md_en    = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("after-rst idle stall", {31'b0, bus.stall}, 32'h0);
        @(posedge clk);
        #1;
        apply(mv(3'b000, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT), 100);

        check_int("scoreboard empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
